// File: rtl/msk_pipe_ctrl.sv
// msk_pipe_ctrl: load-enable sequencer for a chain of LAT masked-register stages.
// Every stage is an enable-less masked register with a hold/load mux in front;
// this block decides, each cycle, which of those muxes select "load".
// The pipeline is elastic and bubble-collapsing (an empty stage always accepts
// from its predecessor), and any cycle that would move valid data into a stage
// is held back until the PRNG offers a fresh randomness word, so that re-masking
// never reuses randomness. A cycle that only shifts bubbles, or a word that only
// leaves through the output port, consumes no randomness.
module msk_pipe_ctrl #(
   parameter int LAT = 3,
   parameter int CW  = $clog2(LAT + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   output logic            out_valid,
   input  logic            out_ready,
   input  logic            rnd_valid,
   output logic            rnd_ready,
   output logic [LAT-1:0]  stage_en,
   output logic [LAT-1:0]  stage_valid,
   output logic [CW-1:0]   occupancy,
   output logic            busy
);

   // Registered valid bit of each stage; the only state in this block.
   logic [LAT-1:0] v_q;
   logic [LAT-1:0] v_d;

   // Valid bit presented at the mux input of each stage (stage 0 sees the port).
   logic [LAT-1:0] vin;
   // Candidate enables: stage i could load if it is empty or its successor moves.
   logic [LAT-1:0] cand;
   logic           need;
   logic           go;
   logic           out_xfer;

   // Build the per-stage input valid vector from the stage chain.
   always_comb begin
      // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
      vin    = '0;
      vin[0] = in_valid;
      for (int i = 1; i < LAT; i++) begin
         vin[i] = v_q[i-1];
      end
   end

   // Ripple the downstream-ready condition back from the output so bubbles collapse.
   always_comb begin
      cand          = '0;
      cand[LAT-1]   = ~v_q[LAT-1] | out_ready;
      for (int i = LAT - 2; i >= 0; i--) begin
         cand[i] = ~v_q[i] | cand[i+1];
      end
   end

   // Randomness gating: loads of valid data wait for rnd_valid, pure bubble shifts do not.
   always_comb begin
      need      = |(cand & vin);
      go        = rnd_valid | ~need;
      stage_en  = flush ? '0 : (cand & {LAT{go}});
      in_ready  = stage_en[0];
      rnd_ready = need & rnd_valid & ~flush;
      out_xfer  = v_q[LAT-1] & out_ready;
   end

   // Next-state valid bits: load, hold, drain through the output port, or flush.
   always_comb begin
      v_d = v_q;
      for (int i = 0; i < LAT; i++) begin
         if (stage_en[i]) begin
            v_d[i] = vin[i];
         end
      end
      // The last word may leave even on a cycle where no stage is allowed to load.
      if (out_xfer && !stage_en[LAT-1]) begin
         v_d[LAT-1] = 1'b0;
      end
      if (flush) begin
         v_d = '0;
      end
   end

   // Stage valid register; reset drops every in-flight word.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: only the control valid bits are reset; the masked share registers need no reset because a cleared valid bit makes their contents don't-care.
      if (!rst_n) begin
         v_q <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         v_q <= v_d;
      end
   end

   // Population count of the registered valid bits (no path from any input).
   always_comb begin
      occupancy = '0;
      for (int i = 0; i < LAT; i++) begin
         occupancy = occupancy + CW'(v_q[i]);
      end
   end

   assign stage_valid = v_q;
   assign out_valid   = v_q[LAT-1];
   assign busy        = |v_q;

endmodule
